// File: rtl/window_gen_pkg.sv
// Shared constants, pixel type and counter-width helper for the Harris corner pipeline.
package window_gen_pkg;

  localparam int PIX_W  = 8;
  localparam int WIN    = 6;
  localparam int GRAD_W = 16;

  typedef logic [PIX_W-1:0] pix_t;

  // Counter width for a dimension of n; never below one bit.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/window_gen_if.sv
// Pixel stream in, WIN x WIN window out; the window generator uses the master side.
interface window_gen_if
  import window_gen_pkg::*;
#(
  parameter int IMG_W = 64,
  parameter int IMG_H = 64
);

  pix_t                       pix_in;
  logic                       pix_valid;
  pix_t                       window [0:WIN-1][0:WIN-1];
  logic                       win_valid;
  logic [cnt_w(IMG_H)-1:0]    win_row;
  logic [cnt_w(IMG_W)-1:0]    win_col;
  logic                       frame_done;

  modport master (
    input  pix_in,
    input  pix_valid,
    output window,
    output win_valid,
    output win_row,
    output win_col,
    output frame_done
  );

  modport slave (
    output pix_in,
    output pix_valid,
    input  window,
    input  win_valid,
    input  win_row,
    input  win_col,
    input  frame_done
  );

endinterface

// File: rtl/window_gen_line_buffer.sv
// One image row of delay (DEPTH accepted pixels) using a circular RAM; read is combinational
// so dout is the pixel written DEPTH enables ago. Holds when en is low; no backpressure.
module line_buffer
  import window_gen_pkg::*;
#(
  parameter int DEPTH = 64
) (
  input  logic clk,
  input  logic en,
  input  pix_t din,
  output pix_t dout
);

  localparam int AW = cnt_w(DEPTH);
  localparam logic [AW-1:0] PTR_LAST = AW'(DEPTH - 1);

  pix_t            mem [0:DEPTH-1];
  logic [AW-1:0]   ptr;

  assign dout = mem[ptr];

  // The pointer is deliberately unreset: the delay is relative, and the window
  // logic never exposes contents until enough rows have passed since reset.
  always_ff @(posedge clk) begin
    if (en) begin
      mem[ptr] <= din;
      ptr      <= (ptr >= PTR_LAST) ? '0 : ptr + AW'(1);
    end
  end

endmodule

// File: rtl/window_gen.sv
// Raster pixels in, registered WIN x WIN window out one cycle after each accepted pixel;
// pix_valid low stalls everything (win_valid/frame_done drop for that cycle), no backpressure.
module window_gen
  import window_gen_pkg::*;
#(
  parameter int IMG_W = 64,
  parameter int IMG_H = 64
) (
  input  logic          clk,
  input  logic          reset,
  window_gen_if.master  bus
);

  localparam int CW = cnt_w(IMG_W);
  localparam int RW = cnt_w(IMG_H);

  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);
  localparam logic [CW-1:0] COL_WIN  = CW'(WIN - 1);
  localparam logic [RW-1:0] ROW_WIN  = RW'(WIN - 1);

  logic            accept;
  logic [CW-1:0]   col_q;
  logic [RW-1:0]   row_q;

  pix_t            lb_din [1:WIN-1];
  pix_t            tap    [1:WIN-1];
  pix_t            win_q  [0:WIN-1][0:WIN-1];

  logic            win_valid_q;
  logic            frame_done_q;
  logic [RW-1:0]   win_row_q;
  logic [CW-1:0]   win_col_q;

  assign accept = bus.pix_valid & ~reset;

  // Cascade: tap k is the pixel k rows above the one being accepted.
  for (genvar k = 1; k < WIN; k++) begin : g_lb
    if (k == 1) begin : g_first
      assign lb_din[k] = bus.pix_in;
    end else begin : g_next
      assign lb_din[k] = tap[k-1];
    end

    line_buffer #(
      .DEPTH (IMG_W)
    ) u_lb (
      .clk  (clk),
      .en   (accept),
      .din  (lb_din[k]),
      .dout (tap[k])
    );
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      col_q <= '0;
      row_q <= '0;
    end else if (accept) begin
      if (col_q == COL_LAST) begin
        col_q <= '0;
        row_q <= (row_q == ROW_LAST) ? '0 : row_q + RW'(1);
      end else begin
        col_q <= col_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < WIN; i++) begin
        for (int j = 0; j < WIN; j++) begin
          win_q[i][j] <= '0;
        end
      end
    end else if (accept) begin
      for (int i = 0; i < WIN; i++) begin
        for (int j = 0; j < WIN - 1; j++) begin
          win_q[i][j] <= win_q[i][j+1];
        end
      end
      for (int i = 0; i < WIN - 1; i++) begin
        win_q[i][WIN-1] <= tap[WIN-1-i];
      end
      win_q[WIN-1][WIN-1] <= bus.pix_in;
    end
  end

  // Gating on the position of the accepted pixel keeps row-wrap, frame-wrap and
  // post-reset stale columns/rows out of any emitted window.
  always_ff @(posedge clk) begin
    if (reset) begin
      win_valid_q  <= 1'b0;
      frame_done_q <= 1'b0;
      win_row_q    <= '0;
      win_col_q    <= '0;
    end else begin
      win_valid_q  <= accept && (row_q >= ROW_WIN) && (col_q >= COL_WIN);
      frame_done_q <= accept && (row_q == ROW_LAST) && (col_q == COL_LAST);
      if (accept) begin
        win_row_q <= row_q;
        win_col_q <= col_q;
      end
    end
  end

  assign bus.window     = win_q;
  assign bus.win_valid  = win_valid_q;
  assign bus.frame_done = frame_done_q;
  assign bus.win_row    = win_row_q;
  assign bus.win_col    = win_col_q;

endmodule

// File: tb/tb_window_gen.sv
// Directed ramp-frame bench for window_gen on an 8x8 image with closed-form expected windows.
module tb_window_gen;
  import window_gen_pkg::*;

  localparam int W = 8;
  localparam int H = 8;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  window_gen_if #(.IMG_W(W), .IMG_H(H)) bus ();

  window_gen #(.IMG_W(W), .IMG_H(H)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d, want %0d", tag, got, exp);
    end
  endtask

  // Drive one edge, then sample 1 time unit after it.
  task automatic step(input logic v, input int pix, input logic rst);
    bus.pix_valid = v;
    bus.pix_in    = PIX_W'(pix);
    reset         = rst;
    @(posedge clk);
    #1;
  endtask

  task automatic win_cmp(input int base, input int r, input int c);
    int nbad;
    nbad = 0;
    for (int i = 0; i < WIN; i++)
      for (int j = 0; j < WIN; j++)
        if (int'(bus.window[i][j]) != base + W * (r - WIN + 1 + i) + (c - WIN + 1 + j))
          nbad++;
    chk($sformatf("window r%0d c%0d bad cells", r, c), nbad, 0);
  endtask

  task automatic zero_cmp(input string tag);
    int nz;
    nz = 0;
    for (int i = 0; i < WIN; i++)
      for (int j = 0; j < WIN; j++)
        if (bus.window[i][j] != '0) nz++;
    chk(tag, nz, 0);
    chk({tag, " valid"}, int'(bus.win_valid), 0);
    chk({tag, " fdone"}, int'(bus.frame_done), 0);
    chk({tag, " row"}, int'(bus.win_row), 0);
    chk({tag, " col"}, int'(bus.win_col), 0);
  endtask

  // Full ramp frame (value = base + W*r + c) with `stalls` idle cycles after each pixel.
  task automatic send_frame(input int base, input int stalls, output int nwin);
    int exp_v;
    nwin = 0;
    for (int r = 0; r < H; r++) begin
      for (int c = 0; c < W; c++) begin
        step(1'b1, base + W * r + c, 1'b0);
        exp_v = (r >= WIN - 1 && c >= WIN - 1) ? 1 : 0;
        chk($sformatf("valid r%0d c%0d", r, c), int'(bus.win_valid), exp_v);
        chk($sformatf("fdone r%0d c%0d", r, c), int'(bus.frame_done),
            (r == H - 1 && c == W - 1) ? 1 : 0);
        chk($sformatf("newest r%0d c%0d", r, c), int'(bus.window[WIN-1][WIN-1]), base + W * r + c);
        if (exp_v == 1) begin
          chk($sformatf("win_row r%0d c%0d", r, c), int'(bus.win_row), r);
          chk($sformatf("win_col r%0d c%0d", r, c), int'(bus.win_col), c);
          win_cmp(base, r, c);
        end
        if (bus.win_valid) nwin++;
        for (int s = 0; s < stalls; s++) begin
          step(1'b0, 8'hAA, 1'b0);
          chk("stall valid", int'(bus.win_valid), 0);
          chk("stall fdone", int'(bus.frame_done), 0);
          chk("stall row", int'(bus.win_row), r);
          chk("stall col", int'(bus.win_col), c);
          chk("stall newest", int'(bus.window[WIN-1][WIN-1]), base + W * r + c);
        end
      end
    end
  endtask

  initial begin
    int n1;
    int n2;
    bus.pix_valid = 1'b0;
    bus.pix_in    = '0;
    reset         = 1'b1;
    step(1'b0, 0, 1'b1);
    step(1'b0, 0, 1'b1);

    // Reset together with a valid pixel: pixel must be dropped.
    step(1'b1, 255, 1'b1);
    zero_cmp("reset+valid");

    // Plain ramp, covering row wrap and frame_done.
    send_frame(0, 0, n1);
    chk("windows ramp", n1, 9);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 0, 1'b0);
      chk("idle valid", int'(bus.win_valid), 0);
    end

    // Stalled ramp (1,0,0 pattern).
    send_frame(0, 2, n1);
    chk("windows stalled", n1, 9);

    // Back-to-back frames, second offset by 100.
    send_frame(0, 0, n1);
    send_frame(100, 0, n2);
    chk("windows b2b", n1 + n2, 18);

    // Reset mid-frame after pixel 50, then a fresh ramp.
    for (int p = 0; p <= 50; p++) step(1'b1, p, 1'b0);
    step(1'b0, 0, 1'b1);
    zero_cmp("mid reset");
    send_frame(50, 0, n1);
    chk("windows after reset", n1, 9);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
